regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised successor to the 8×16 single-read-port register file used by the datapath. It adds configurable width and depth, a second read port, optional same-cycle write-to-read bypass, and a multi-cycle bulk-clear sequencer with a ready/busy handshake on the write port. It sits in the datapath where the register file sits today and feeds both ALU operand paths.

## Interface
- WIDTH, 16, register width in bits
- DEPTH, 8, number of registers; any value ≥ 2; AW = $clog2(DEPTH) is derived
- BYPASS, 1, when 1, an accepted write is forwarded combinationally to a matching read port in the same cycle
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, no other clock domains
- data_in  in  WIDTH  write data
- writenum  in  AW  write address
- write  in  1  write request
- write_ready  out  1  write accepted this cycle iff write && write_ready
- readnum_a  in  AW  read address, port A
- data_out_a  out  WIDTH  read data, port A
- readnum_b  in  AW  read address, port B
- data_out_b  out  WIDTH  read data, port B
- clear  in  1  request to zero all registers
- busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse when the sweep completes

## Operation
- **Storage:** DEPTH × WIDTH flops. No memory macro.
- **Reset:** all registers are 0, FSM is in RF_IDLE, pointer is 0, busy=0, write_ready=1, clear_done=0.
- **Write:** on a rising edge with write && write_ready, reg[writenum] <= data_in. A write with writenum ≥ DEPTH is accepted and discarded.
- **Read:** combinational. data_out_x = reg[readnum_x]. A readnum ≥ DEPTH returns 0.
- **Bypass (BYPASS=1):**
  - If a write is accepted and writenum == readnum_x < DEPTH, data_out_x = data_in in that same cycle.
  - Both ports bypass independently.
  - Bypass is never active while busy.
- **FSM:**
  - RF_IDLE → RF_CLEAR when clear is sampled high on an edge; pointer <= 0.
  - In RF_CLEAR, each edge zeroes reg[pointer] and increments the pointer.
  - RF_CLEAR → RF_IDLE on the edge that zeroes reg[DEPTH-1].
- **Handshake:**
  - write_ready = (state == RF_IDLE).
  - Writes presented while busy are not accepted; the requester holds write until write_ready is high.
  - clear while in RF_CLEAR is ignored.
- **Simultaneous write and clear in RF_IDLE:** the write commits on that edge. The sweep starts on the same edge and zeroes the written register later in the sweep.
- **Reads during a sweep:** return current contents, so already-cleared entries read 0 and uncleared entries keep their old value.

## Timing
- **Write latency:** data is visible on a read port through storage from the cycle after the edge. With BYPASS=1 it is visible combinationally in the same cycle.
- **Clear sweep, with clear sampled at edge E0:**
  - busy=1 from E0 until E_DEPTH, i.e. exactly DEPTH cycles.
  - reg[k] reads 0 after edge E(k+1).
  - clear_done=1 for the single cycle after E_DEPTH.
- **Output registration:** busy and clear_done are registered. write_ready is decoded from registered state only, with no input-to-output combinational path.
- **Reset mid-sweep:** immediate return to the reset state; all registers are 0 and no clear_done pulse is issued.
- **Pointer width:** AW bits. Pointer wrap is never reached, because the FSM exits at DEPTH-1, which also holds for non-power-of-two DEPTH.

## Structure
- **Package regfile_pkg:**
  - typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t
  - default constants RF_WIDTH=16 and RF_DEPTH=8
- **Sub-module regfile_clear_seq:**
  - contains the FSM, pointer, busy, clear_done and write_ready
  - exports clr_en and clr_addr to the storage array
- **Top:** holds the storage, write decode and both read muxes with bypass.

## Test plan
- **Reset and basic write/read:** after reset, both ports read 0x0000 at every address. Write 0x0003 to R0, then read A=R0 → 0x0003 and B=R7 → 0x0000.
- **No-write:** write=0 with data 0x003F to R0 → R0 stays 0x0003. Also write 0x0007 to R7 and read it back on both ports → 0x0007.
- **Bypass:** with BYPASS=1, write 0xC003 to R2 with readnum_a=R2 → data_out_a=0xC003 in the same cycle, before the edge. Repeat with BYPASS=0 → the old value is seen until the edge.
- **Clear sweep:** fill R0–R7 with 0x8003 + k, then pulse clear. Check:
  - busy is high for exactly 8 cycles
  - R3 reads 0x8006 until E4 and 0x0000 after
  - clear_done pulses once after E8
- **Held write during clear:** assert write 0xF003 to R4 throughout the sweep → write_ready=0 and R4 is not written. The write is accepted on the first cycle after busy drops, and R4 then reads 0xF003.
- **Reset mid-sweep:** assert reset at E3 → busy=0 and write_ready=1 immediately, all registers read 0, and no clear_done pulse. Also test DEPTH=5, WIDTH=32: readnum=6 → 0, and a sweep lasts 5 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

    typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

    localparam int RF_WIDTH = 16;
    localparam int RF_DEPTH = 8;

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks a pointer over every register, one per clock,
// and owns the write-port handshake so writes are held off during a sweep.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clear_i,
    output logic          busy_o,
    output logic          clear_done_o,
    output logic          write_ready_o,
    output logic          clr_en_o,
    output logic [AW-1:0] clr_addr_o
);

    // The sweep ends on the entry DEPTH-1, so the pointer never wraps even
    // when DEPTH is not a power of two.
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_t     state_q;
    logic [AW-1:0] ptr_q;
    logic          busy_q;
    logic          done_q;

    // Sweep FSM with registered busy/clear_done outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= RF_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RF_IDLE: begin
                    if (clear_i) begin
                        state_q <= RF_CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (ptr_q == LAST) begin
                        state_q <= RF_IDLE;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + AW'(1);
                    end
                end
            endcase
        end
    end

    // Handshake and clear strobe decode from registered state only.
    always_comb begin
        write_ready_o = (state_q == RF_IDLE);
        clr_en_o      = (state_q == RF_CLEAR);
        clr_addr_o    = ptr_q;
        busy_o        = busy_q;
        clear_done_o  = done_q;
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised two-read-port register file with optional write-to-read
// bypass and a multi-cycle bulk clear. Storage is plain flops.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    writenum,
    input  logic             write,
    output logic             write_ready,
    input  logic [AW-1:0]    readnum_a,
    output logic [WIDTH-1:0] data_out_a,
    input  logic [AW-1:0]    readnum_b,
    output logic [WIDTH-1:0] data_out_b,
    input  logic             clear,
    output logic             busy,
    output logic             clear_done
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic             wr_acc;
    logic             clr_en;
    logic [AW-1:0]    clr_addr;
    logic             byp_a;
    logic             byp_b;

    // Addresses at or above DEPTH are legal on the bus but map to nothing.
    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    regfile_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk_i         (clk),
        .reset_i       (reset),
        .clear_i       (clear),
        .busy_o        (busy),
        .clear_done_o  (clear_done),
        .write_ready_o (write_ready),
        .clr_en_o      (clr_en),
        .clr_addr_o    (clr_addr)
    );

    assign wr_acc = write && write_ready;

    // Next-state per entry: sweep zeroing wins, but writes and the sweep are
    // mutually exclusive anyway since writes are only accepted when idle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (clr_en && (clr_addr == AW'(i))) begin
                regs_d[i] = '0;
            end else if (wr_acc && (writenum == AW'(i))) begin
                regs_d[i] = data_in;
            end
        end
    end

    // Storage array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read muxes; unmatched (out-of-range) addresses fall through to zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (readnum_a == AW'(i)) rd_a = regs_q[i];
            if (readnum_b == AW'(i)) rd_b = regs_q[i];
        end
    end

    // Same-cycle forwarding of an accepted write; never active while busy
    // because wr_acc already requires write_ready.
    always_comb begin
        byp_a      = BYPASS && wr_acc && (writenum == readnum_a) && in_range(readnum_a);
        byp_b      = BYPASS && wr_acc && (writenum == readnum_b) && in_range(readnum_b);
        data_out_a = byp_a ? data_in : rd_a;
        data_out_b = byp_b ? data_in : rd_b;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 8x16 with and without bypass,
// plus a 5x32 instance for non-power-of-two depth.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;
    logic        clear;

    logic        dut_wr_rdy, dut_busy, dut_done;
    logic [15:0] dut_a, dut_b;
    logic        nb_wr_rdy, nb_busy, nb_done;
    logic [15:0] nb_a, nb_b;

    logic [31:0] d5_data_in;
    logic [2:0]  d5_writenum;
    logic        d5_write;
    logic [2:0]  d5_readnum_a;
    logic [2:0]  d5_readnum_b;
    logic        d5_clear;
    logic        d5_wr_rdy, d5_busy, d5_done;
    logic [31:0] d5_a, d5_b;

    int checks = 0;
    int errors = 0;
    int busy_cnt;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1)) u_dut (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum),
        .write(write), .write_ready(dut_wr_rdy), .readnum_a(readnum_a),
        .data_out_a(dut_a), .readnum_b(readnum_b), .data_out_b(dut_b),
        .clear(clear), .busy(dut_busy), .clear_done(dut_done)
    );

    regfile_mp #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0)) u_nb (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum),
        .write(write), .write_ready(nb_wr_rdy), .readnum_a(readnum_a),
        .data_out_a(nb_a), .readnum_b(readnum_b), .data_out_b(nb_b),
        .clear(clear), .busy(nb_busy), .clear_done(nb_done)
    );

    regfile_mp #(.WIDTH(32), .DEPTH(5), .BYPASS(1'b1)) u_d5 (
        .clk(clk), .reset(reset), .data_in(d5_data_in), .writenum(d5_writenum),
        .write(d5_write), .write_ready(d5_wr_rdy), .readnum_a(d5_readnum_a),
        .data_out_a(d5_a), .readnum_b(d5_readnum_b), .data_out_b(d5_b),
        .clear(d5_clear), .busy(d5_busy), .clear_done(d5_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        data_in      = '0;
        writenum     = '0;
        write        = 1'b0;
        readnum_a    = '0;
        readnum_b    = '0;
        clear        = 1'b0;
        d5_data_in   = '0;
        d5_writenum  = '0;
        d5_write     = 1'b0;
        d5_readnum_a = '0;
        d5_readnum_b = '0;
        d5_clear     = 1'b0;
        #12;
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst_write_ready", 32'(dut_wr_rdy), 32'd1);
        chk("rst_busy", 32'(dut_busy), 32'd0);
        chk("rst_clear_done", 32'(dut_done), 32'd0);
        chk("rst_d5_busy", 32'(d5_busy), 32'd0);
        for (int k = 0; k < 8; k++) begin
            readnum_a = 3'(k);
            readnum_b = 3'(7 - k);
            #1;
            chk("rst_read_a", 32'(dut_a), 32'h0);
            chk("rst_read_b", 32'(dut_b), 32'h0);
        end

        // Basic write R0 = 0x0003
        write = 1'b1; writenum = 3'd0; data_in = 16'h0003;
        tick();
        write = 1'b0;
        readnum_a = 3'd0; readnum_b = 3'd7;
        #1;
        chk("wr_r0_a", 32'(dut_a), 32'h0003);
        chk("wr_r7_b", 32'(dut_b), 32'h0000);
        chk("wr_r0_nb", 32'(nb_a), 32'h0003);

        // No-write: R0 must keep its value
        write = 1'b0; writenum = 3'd0; data_in = 16'h003F;
        tick();
        chk("nowrite_r0", 32'(dut_a), 32'h0003);

        // R7 = 0x0007, read on both ports
        write = 1'b1; writenum = 3'd7; data_in = 16'h0007;
        tick();
        write = 1'b0;
        readnum_a = 3'd7; readnum_b = 3'd7;
        #1;
        chk("r7_a", 32'(dut_a), 32'h0007);
        chk("r7_b", 32'(dut_b), 32'h0007);

        // Bypass: same-cycle visibility only with BYPASS=1
        write = 1'b1; writenum = 3'd2; data_in = 16'hC003;
        readnum_a = 3'd2; readnum_b = 3'd3;
        #1;
        chk("byp_a", 32'(dut_a), 32'hC003);
        chk("byp_b_nomatch", 32'(dut_b), 32'h0000);
        chk("nobyp_a_old", 32'(nb_a), 32'h0000);
        readnum_b = 3'd2;
        #1;
        chk("byp_b", 32'(dut_b), 32'hC003);
        chk("nobyp_b_old", 32'(nb_b), 32'h0000);
        tick();
        write = 1'b0;
        #1;
        chk("nobyp_a_after", 32'(nb_a), 32'hC003);
        chk("byp_a_after", 32'(dut_a), 32'hC003);

        // Fill R0..R7 with 0x8003 + k
        for (int k = 0; k < 8; k++) begin
            write = 1'b1; writenum = 3'(k); data_in = 16'(16'h8003 + k);
            tick();
        end
        write = 1'b0;
        readnum_a = 3'd3; readnum_b = 3'd4;
        #1;
        chk("fill_r3", 32'(dut_a), 32'h8006);
        chk("fill_r4", 32'(nb_b), 32'h8007);

        // Clear sweep with a held write to R4 starting right after E0
        clear = 1'b1;
        tick();
        clear = 1'b0;
        write = 1'b1; writenum = 3'd4; data_in = 16'hF003;
        #1;
        busy_cnt = 0;
        if (dut_busy) busy_cnt++;
        chk("e0_busy", 32'(dut_busy), 32'd1);
        chk("e0_write_ready", 32'(dut_wr_rdy), 32'd0);
        chk("e0_r3", 32'(dut_a), 32'h8006);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (dut_busy) busy_cnt++;
            chk("sweep_busy", 32'(dut_busy), (k < 8) ? 32'd1 : 32'd0);
            chk("sweep_write_ready", 32'(dut_wr_rdy), (k < 8) ? 32'd0 : 32'd1);
            chk("sweep_clear_done", 32'(dut_done), (k == 8) ? 32'd1 : 32'd0);
            chk("sweep_r3", 32'(dut_a), (k >= 4) ? 32'h0 : 32'h8006);
            chk("sweep_r4_held", 32'(nb_b), (k >= 5) ? 32'h0 : 32'h8007);
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd8);
        chk("post_bypass_r4", 32'(dut_b), 32'hF003);
        tick();
        write = 1'b0;
        readnum_a = 3'd7;
        #1;
        chk("held_write_r4", 32'(dut_b), 32'hF003);
        chk("held_write_r4_nb", 32'(nb_b), 32'hF003);
        chk("done_dropped", 32'(dut_done), 32'd0);
        chk("post_sweep_r7", 32'(dut_a), 32'h0);

        // Reset in the middle of a sweep
        write = 1'b1; writenum = 3'd6; data_in = 16'h6666;
        tick();
        write = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        tick();
        tick();
        readnum_b = 3'd6;
        #1;
        chk("mid_r6_before_rst", 32'(dut_b), 32'h6666);
        chk("mid_busy_before_rst", 32'(dut_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(dut_busy), 32'd0);
        chk("mid_rst_write_ready", 32'(dut_wr_rdy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            readnum_a = 3'(k);
            #1;
            chk("mid_rst_zero", 32'(dut_a), 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("mid_rst_no_done", 32'(dut_done), 32'd0);
        end

        // DEPTH=5, WIDTH=32
        d5_write = 1'b1; d5_writenum = 3'd4; d5_data_in = 32'hDEADBEEF;
        tick();
        d5_writenum = 3'd6; d5_data_in = 32'h12345678;
        d5_readnum_a = 3'd4; d5_readnum_b = 3'd6;
        #1;
        chk("d5_oob_nobypass", d5_b, 32'h0);
        tick();
        d5_write = 1'b0;
        #1;
        chk("d5_r4", d5_a, 32'hDEADBEEF);
        chk("d5_r6_oob", d5_b, 32'h0);
        d5_clear = 1'b1;
        tick();
        d5_clear = 1'b0;
        chk("d5_e0_busy", 32'(d5_busy), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("d5_sweep_busy", 32'(d5_busy), (k < 5) ? 32'd1 : 32'd0);
            chk("d5_sweep_done", 32'(d5_done), (k == 5) ? 32'd1 : 32'd0);
            chk("d5_sweep_r4", d5_a, (k >= 5) ? 32'h0 : 32'hDEADBEEF);
        end
        tick();
        chk("d5_done_drop", 32'(d5_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
